// File: rtl/fifo_uart_wb.sv
// fifo_uart_wb - Wishbone slave UART with TX/RX FIFOs, sticky error flags and a
// level interrupt. Registers: 0x0 DATA, 0x4 STATUS, 0x8 DIV, 0xC CTRL.
// The bit period is DIV+2 clocks. An empty DATA read returns all ones.
// Define UART_PARITY_EN to add the optional parity bit (CTRL[8]=PEN,
// CTRL[9]=ODD). Without it the UART is 8N1 only.
module fifo_uart_wb #(
    parameter int          TX_DEPTH    = 16,
    parameter int          RX_DEPTH    = 16,
    parameter logic [31:0] DEFAULT_DIV = 32'd1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [3:2]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        irq_o
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Bus and configuration
    logic        r_ack;
    logic [31:0] r_div;
    logic [2:0]  r_ie;
    logic        r_rxovf, r_frmerr, r_parerr, r_txovf;
    logic        w_pen, w_odd;
    logic        w_wr, w_pop_req, w_clr;
    logic [32:0] w_div_p1, w_half_m1;
    logic [31:0] w_status;

    // TX path
    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] r_tx_wp, r_tx_rp;
    logic [TX_AW:0]   r_tx_level;
    state_t           r_tx_state, w_tx_next;
    logic [32:0]      r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_shift;
    logic             r_tx_pen, r_tx_par;
    logic             w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_done, w_tx_busy;

    // RX path
    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] r_rx_wp, r_rx_rp;
    logic [RX_AW:0]   r_rx_level;
    state_t           r_rx_state, w_rx_next;
    logic [32:0]      r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic             r_rx_s1, r_rx_s2, r_rx_prev, r_rx_pen, r_rx_odd;
    logic             w_rx_full, w_rx_empty, w_rx_done, w_rx_byte, w_rx_frm, w_rx_par;
    logic             w_rx_pop, w_rx_wr, w_rx_ovf;

    assign w_wr      = wb_stb_i & ~r_ack & wb_we_i;
    assign w_pop_req = wb_stb_i & r_ack & ~wb_we_i & (wb_adr_i == 2'd0) & wb_sel_i[0];
    assign w_clr     = w_wr & (wb_adr_i == 2'd1) & wb_sel_i[0];
    assign wb_ack_o  = r_ack;
    assign w_div_p1  = {1'b0, r_div} + 33'd1;
    assign w_half_m1 = (({1'b0, r_div} + 33'd2) >> 1) - 33'd1;

    // Single-cycle acknowledge, never back-to-back
    // NOTE: all clocked state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_ack <= 1'b0;
        else          r_ack <= wb_stb_i & ~r_ack;
    end

    // DIV (byte-lane writable) and interrupt enables
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_div <= DEFAULT_DIV;
            r_ie  <= '0;
        end else if (w_wr) begin
            if (wb_adr_i == 2'd2) begin
                for (int i = 0; i < 4; i++)
                    if (wb_sel_i[i]) r_div[8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
            if (wb_adr_i == 2'd3 && wb_sel_i[0]) r_ie <= wb_dat_i[2:0];
        end
    end

`ifdef UART_PARITY_EN
    logic r_pen, r_odd;
    // Parity controls live in CTRL byte lane 1
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_pen <= 1'b0;
            r_odd <= 1'b0;
        end else if (w_wr && wb_adr_i == 2'd3 && wb_sel_i[1]) begin
            r_pen <= wb_dat_i[8];
            r_odd <= wb_dat_i[9];
        end
    end
    assign w_pen = r_pen;
    assign w_odd = r_odd;
`else
    assign w_pen = 1'b0;
    assign w_odd = 1'b0;
`endif

    // ---------------- TX ----------------
    assign w_tx_full  = (r_tx_level == (TX_AW+1)'(TX_DEPTH));
    assign w_tx_empty = (r_tx_level == '0);
    assign w_tx_push  = w_wr & (wb_adr_i == 2'd0) & wb_sel_i[0] & ~w_tx_full;
    assign w_tx_done  = (r_tx_cnt == '0);
    assign w_tx_busy  = ~w_tx_empty | (r_tx_state != S_IDLE);

    // TX next state; a pop loads the shifter with the FIFO head
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        case (r_tx_state)
            S_IDLE:   if (!w_tx_empty) begin w_tx_next = S_START; w_tx_pop = 1'b1; end
            S_START:  if (w_tx_done) w_tx_next = S_DATA;
            S_DATA:   if (w_tx_done && r_tx_bit == 3'd7) w_tx_next = r_tx_pen ? S_PARITY : S_STOP;
            S_PARITY: if (w_tx_done) w_tx_next = S_STOP;
            S_STOP:   if (w_tx_done) begin
                          if (!w_tx_empty) begin w_tx_next = S_START; w_tx_pop = 1'b1; end
                          else w_tx_next = S_IDLE;
                      end
            default:  w_tx_next = S_IDLE;
        endcase
    end

    // TX state, bit timer and shifter; PEN/ODD are captured per frame
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_pen   <= 1'b0;
            r_tx_par   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_pop || (r_tx_state != S_IDLE && w_tx_done)) r_tx_cnt <= w_div_p1;
            else if (!w_tx_done) r_tx_cnt <= r_tx_cnt - 33'd1;
            if (w_tx_pop) begin
                r_tx_shift <= r_tx_mem[r_tx_rp];
                r_tx_bit   <= '0;
                r_tx_pen   <= w_pen;
                r_tx_par   <= (^r_tx_mem[r_tx_rp]) ^ w_odd;
            end else if (r_tx_state == S_DATA && w_tx_done) begin
                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                r_tx_bit   <= r_tx_bit + 3'd1;
            end
        end
    end

    // Serial line driven straight from state so reset forces it high at once
    always_comb begin
        case (r_tx_state)
            S_START:  tx_o = 1'b0;
            S_DATA:   tx_o = r_tx_shift[0];
            S_PARITY: tx_o = r_tx_par;
            default:  tx_o = 1'b1;
        endcase
    end

    // ---------------- RX ----------------
    assign w_rx_full  = (r_rx_level == (RX_AW+1)'(RX_DEPTH));
    assign w_rx_empty = (r_rx_level == '0);
    assign w_rx_done  = (r_rx_cnt == '0);
    assign w_rx_pop   = w_pop_req & ~w_rx_empty;
    assign w_rx_wr    = w_rx_byte & (~w_rx_full | w_rx_pop);
    assign w_rx_ovf   = w_rx_byte & w_rx_full & ~w_rx_pop;

    // RX next state and per-sample events
    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_byte = 1'b0;
        w_rx_frm  = 1'b0;
        w_rx_par  = 1'b0;
        case (r_rx_state)
            S_IDLE:   if (r_rx_prev && !r_rx_s2) w_rx_next = S_START;
            S_START:  if (w_rx_done) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:   if (w_rx_done && r_rx_bit == 3'd7) w_rx_next = r_rx_pen ? S_PARITY : S_STOP;
            S_PARITY: if (w_rx_done) begin
                          w_rx_next = S_STOP;
                          w_rx_par  = r_rx_s2 ^ (^r_rx_shift) ^ r_rx_odd;
                      end
            S_STOP:   if (w_rx_done) begin
                          w_rx_next = S_IDLE;
                          w_rx_byte = r_rx_s2;
                          w_rx_frm  = ~r_rx_s2;
                      end
            default:  w_rx_next = S_IDLE;
        endcase
    end

    // Synchroniser, RX state, half-bit start qualification and data shifter
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_pen   <= 1'b0;
            r_rx_odd   <= 1'b0;
        end else begin
            r_rx_s1    <= rx_i;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_next;
            if (r_rx_state == S_IDLE && w_rx_next == S_START) begin
                r_rx_cnt <= w_half_m1;
                r_rx_bit <= '0;
                r_rx_pen <= w_pen;
                r_rx_odd <= w_odd;
            end else if (r_rx_state != S_IDLE && w_rx_done) begin
                r_rx_cnt <= w_div_p1;
            end else if (!w_rx_done) begin
                r_rx_cnt <= r_rx_cnt - 33'd1;
            end
            if (r_rx_state == S_DATA && w_rx_done) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end
    end

    // FIFO pointers and levels; simultaneous push and pop leave the level unchanged
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_tx_wp <= '0; r_tx_rp <= '0; r_tx_level <= '0;
            r_rx_wp <= '0; r_rx_rp <= '0; r_rx_level <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            r_tx_level <= r_tx_level + (TX_AW+1)'(w_tx_push) - (TX_AW+1)'(w_tx_pop);
            if (w_rx_wr)  r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
            r_rx_level <= r_rx_level + (RX_AW+1)'(w_rx_wr) - (RX_AW+1)'(w_rx_pop);
        end
    end

    // FIFO storage
    // NOTE: storage arrays carry no reset; pointers and levels alone define validity.
    always_ff @(posedge wb_clk_i) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= wb_dat_i[7:0];
        if (w_rx_wr)   r_rx_mem[r_rx_wp] <= r_rx_shift;
    end

    // Sticky error flags: a new event wins over a same-cycle clear
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rxovf <= 1'b0; r_frmerr <= 1'b0; r_parerr <= 1'b0; r_txovf <= 1'b0;
        end else begin
            r_rxovf  <= w_rx_ovf | (r_rxovf  & ~(w_clr & wb_dat_i[4]));
            r_frmerr <= w_rx_frm | (r_frmerr & ~(w_clr & wb_dat_i[5]));
            r_parerr <= w_rx_par | (r_parerr & ~(w_clr & wb_dat_i[6]));
            r_txovf  <= (w_wr & (wb_adr_i == 2'd0) & wb_sel_i[0] & w_tx_full)
                        | (r_txovf & ~(w_clr & wb_dat_i[7]));
        end
    end

    assign w_status = {8'h00, 8'(r_tx_level), 8'(r_rx_level),
                       r_txovf, r_parerr, r_frmerr, r_rxovf,
                       w_rx_full, w_tx_full, w_tx_busy, ~w_rx_empty};

    // Combinational read mux
    always_comb begin
        case (wb_adr_i)
            2'd0:    wb_dat_o = w_rx_empty ? 32'hFFFF_FFFF : {24'h0, r_rx_mem[r_rx_rp]};
            2'd1:    wb_dat_o = w_status;
            2'd2:    wb_dat_o = r_div;
            default: wb_dat_o = {22'h0, w_odd, w_pen, 5'h0, r_ie};
        endcase
    end

    assign irq_o = (r_ie[0] & ~w_rx_empty) | (r_ie[1] & ~w_tx_busy)
                 | (r_ie[2] & (r_rxovf | r_frmerr | r_parerr | r_txovf));

endmodule

// File: tb/tb_fifo_uart_wb.sv
// Directed testbench for fifo_uart_wb (TX_DEPTH=RX_DEPTH=4, DEFAULT_DIV=1).
module tb_fifo_uart_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        we, stb;
    logic [3:0]  sel;
    logic        ack, tx, irq;
    logic        rx_line;
    logic        rx_drv  = 1'b1;
    logic        loop_en = 1'b0;
    logic        corrupt = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;
    assign rx_line = loop_en ? (tx ^ corrupt) : rx_drv;

    fifo_uart_wb #(.TX_DEPTH(4), .RX_DEPTH(4), .DEFAULT_DIV(32'd1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_dat_o(rdat), .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb),
        .wb_ack_o(ack), .rx_i(rx_line), .tx_o(tx), .irq_o(irq)
    );

`ifdef UART_PARITY_EN
    localparam logic [31:0] CTRL_ALL = 32'h0000_0307;
    localparam logic [31:0] CTRL_PAR = 32'h0000_0300;
`else
    localparam logic [31:0] CTRL_ALL = 32'h0000_0007;
    localparam logic [31:0] CTRL_PAR = 32'h0000_0000;
`endif

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;
    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk); stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
        @(negedge clk); stb = 1'b0; we = 1'b0;
    endtask

    // Returns data sampled during the ack cycle; the pop edge follows
    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk); stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        @(negedge clk); d = rdat;
        @(posedge clk); #1 stb = 1'b0;
    endtask

    task automatic uart_send(input logic [7:0] b, input int period, input logic stop_bit);
        @(negedge clk);
        rx_drv = 1'b0; repeat (period) @(negedge clk);
        for (int i = 0; i < 8; i++) begin rx_drv = b[i]; repeat (period) @(negedge clk); end
        rx_drv = stop_bit; repeat (period) @(negedge clk);
        rx_drv = 1'b1;     repeat (period) @(negedge clk);
    endtask

    // Loopback frame of 0x03 at DIV=2; optionally inverts the parity bit on the line
    task automatic par_frame(input logic flip, output logic pbit);
        int t;
        pbit = 1'bx;
        fork
            wb_write(2'd0, 32'h03, 4'h1);
            begin
                t = 0;
                while (tx !== 1'b0 && t < 50) begin @(negedge clk); t++; end
                check("par_start_seen", 32'(t < 50), 32'd1);
                repeat (36) @(negedge clk);
                corrupt = flip;
                repeat (2) @(negedge clk);
                pbit = tx;
                @(negedge clk);
                corrupt = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic [9:0]  exp_bits;
        logic        pbit;
        int          t, cnt;

        rst = 1'b1; adr = '0; wdat = '0; we = 1'b0; stb = 1'b0; sel = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        rst = 1'b0;

        // Register-level vectors
        vecs[0]  = '{1'b0, 2'd1, 32'h0,         4'hF,    32'h0,         1'b0};
        vecs[1]  = '{1'b0, 2'd2, 32'h0,         4'hF,    32'h1,         1'b0};
        vecs[2]  = '{1'b0, 2'd3, 32'h0,         4'hF,    32'h0,         1'b0};
        vecs[3]  = '{1'b0, 2'd0, 32'h0,         4'hF,    32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{1'b1, 2'd2, 32'h1234_5678, 4'hF,    32'h0,         1'b0};
        vecs[5]  = '{1'b0, 2'd2, 32'h0,         4'hF,    32'h1234_5678, 1'b0};
        vecs[6]  = '{1'b1, 2'd2, 32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 2'd2, 32'h0,         4'hF,    32'h12BB_56DD, 1'b0};
        vecs[8]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF,    32'h0,         1'b1};
        vecs[9]  = '{1'b0, 2'd3, 32'h0,         4'hF,    CTRL_ALL,      1'b1};
        vecs[10] = '{1'b1, 2'd3, 32'h0,         4'hF,    32'h0,         1'b0};
        vecs[11] = '{1'b1, 2'd1, 32'hFF,        4'hF,    32'h0,         1'b0};
        vecs[12] = '{1'b0, 2'd1, 32'h0,         4'hF,    32'h0,         1'b0};
        vecs[13] = '{1'b1, 2'd3, 32'h307,       4'b0010, 32'h0,         1'b0};
        vecs[14] = '{1'b0, 2'd3, 32'h0,         4'hF,    CTRL_PAR,      1'b0};
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].we) wb_write(vecs[i].adr, vecs[i].wdat, vecs[i].sel);
            else begin
                wb_read(vecs[i].adr, d);
                check($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end
        wb_write(2'd3, 32'h0, 4'hF);

        // Ack is a single-cycle pulse
        @(negedge clk); stb = 1'b1; we = 1'b0; adr = 2'd1; sel = 4'hF;
        @(negedge clk); check("ack_high", 32'(ack), 32'd1);
        @(negedge clk); check("ack_no_b2b", 32'(ack), 32'd0);
        stb = 1'b0;

        // TX frame 0xA5 at 8 clk/bit; IE_TXEMPTY tracks tx_busy
        wb_write(2'd3, 32'h2, 4'h1);
        wb_write(2'd2, 32'd6, 4'hF);
        check("t1_irq_idle", 32'(irq), 32'd1);
        wb_write(2'd0, 32'hA5, 4'h1);
        @(posedge clk);
        exp_bits = {1'b1, 8'hA5, 1'b0};
        #45;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t1_bit%0d", k), 32'(tx), 32'(exp_bits[k]));
            if (k < 9) #80;
        end
        #30 check("t1_busy_end", 32'(irq), 32'd0);
        #10 check("t1_idle_after", 32'(irq), 32'd1);

        // Loopback at DIV=2: three contiguous frames take exactly 120 clocks
        wb_write(2'd2, 32'd2, 4'hF);
        loop_en = 1'b1;
        cnt = 0;
        fork
            begin
                wb_write(2'd0, 32'h11, 4'h1);
                wb_write(2'd0, 32'h22, 4'h1);
                wb_write(2'd0, 32'h33, 4'h1);
            end
            begin
                t = 0;
                while (tx !== 1'b0 && t < 50) begin @(negedge clk); t++; end
                while (irq !== 1'b1 && cnt < 1000) begin @(negedge clk); cnt++; end
            end
        join
        check("t2_contiguous", cnt, 32'd120);
        repeat (10) @(negedge clk);
        loop_en = 1'b0;
        wb_read(2'd1, d); check("t2_status", d, 32'h0000_0301);
        wb_read(2'd0, d); check("t2_rd0", d, 32'h11);
        wb_read(2'd0, d); check("t2_rd1", d, 32'h22);
        wb_read(2'd0, d); check("t2_rd2", d, 32'h33);
        wb_read(2'd0, d); check("t2_empty", d, 32'hFFFF_FFFF);
        wb_read(2'd1, d); check("t2_level0", d, 32'h0);

        // RX overflow: five frames into a depth-4 FIFO
        for (int i = 1; i <= 5; i++) uart_send(8'(i), 4, 1'b1);
        wb_read(2'd1, d); check("t3_ovf_status", d, 32'h0000_0419);
        wb_write(2'd1, 32'h10, 4'h1);
        wb_read(2'd1, d); check("t3_ovf_clear", d, 32'h0000_0409);
        for (int i = 1; i <= 4; i++) begin
            wb_read(2'd0, d); check($sformatf("t3_rd%0d", i), d, 32'(i));
        end
        wb_read(2'd0, d); check("t3_empty", d, 32'hFFFF_FFFF);

        // Framing error discards the byte; a short glitch is ignored
        uart_send(8'h5A, 4, 1'b0);
        wb_read(2'd1, d); check("t4_frmerr", d, 32'h0000_0020);
        wb_write(2'd1, 32'h20, 4'h1);
        wb_read(2'd1, d); check("t4_frm_clear", d, 32'h0);
        wb_write(2'd2, 32'd14, 4'hF);
        @(negedge clk); rx_drv = 1'b0;
        repeat (2) @(negedge clk); rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        wb_read(2'd1, d); check("t4_glitch", d, 32'h0);
        uart_send(8'hC3, 16, 1'b1);
        wb_read(2'd0, d); check("t4_rd_div14", d, 32'hC3);

        // Interrupts
        wb_write(2'd3, 32'h1, 4'h1);
        check("t5_irq_none", 32'(irq), 32'd0);
        uart_send(8'h77, 16, 1'b1);
        check("t5_irq_rx", 32'(irq), 32'd1);
        @(negedge clk); stb = 1'b1; we = 1'b0; adr = 2'd0; sel = 4'hF;
        @(negedge clk);
        check("t5_rd", rdat, 32'h77);
        check("t5_irq_before_pop", 32'(irq), 32'd1);
        @(posedge clk); #1;
        check("t5_irq_after_pop", 32'(irq), 32'd0);
        stb = 1'b0;
        wb_write(2'd3, 32'h2, 4'h1);
        check("t5_irq_txempty", 32'(irq), 32'd1);
        wb_write(2'd3, 32'h4, 4'h1);
        check("t5_irq_err_none", 32'(irq), 32'd0);

        // TX overflow, then reset in the middle of a frame
        for (int i = 0; i < 6; i++) wb_write(2'd0, 32'h10 + 32'(i), 4'h1);
        wb_read(2'd1, d); check("t6_txovf", d, 32'h0004_0086);
        check("t6_irq_err", 32'(irq), 32'd1);
        check("t6_tx_midframe", 32'(tx), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_tx", 32'(tx), 32'd1);
        check("t6_rst_irq", 32'(irq), 32'd0);
        @(negedge clk); rst = 1'b0;
        wb_read(2'd1, d); check("t6_rst_status", d, 32'h0);
        wb_read(2'd2, d); check("t6_rst_div", d, 32'h1);
        wb_read(2'd3, d); check("t6_rst_ctrl", d, 32'h0);

`ifdef UART_PARITY_EN
        // Even parity on 0x03 is 0; corrupted on the loop it flags PARERR but keeps the byte
        wb_write(2'd2, 32'd2, 4'hF);
        wb_write(2'd3, 32'h100, 4'h2);
        loop_en = 1'b1;
        par_frame(1'b1, pbit);
        check("par_even_bit", 32'(pbit), 32'd0);
        wb_read(2'd1, d); check("par_err_status", d, 32'h0000_0141);
        wb_read(2'd0, d); check("par_err_byte", d, 32'h03);
        wb_write(2'd1, 32'h40, 4'h1);
        wb_write(2'd3, 32'h300, 4'h2);
        par_frame(1'b0, pbit);
        check("par_odd_bit", 32'(pbit), 32'd1);
        wb_read(2'd1, d); check("par_odd_status", d, 32'h0000_0101);
        wb_read(2'd0, d); check("par_odd_byte", d, 32'h03);
        loop_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
